// File: rtl/ramulator_req_arbiter.sv
// Round-robin request arbiter in front of a memory model wrapper.
// Grants one requester at a time into a registered memory request, tracks
// outstanding reads in a small address table and routes read completions
// back to the requester that issued them.
module ramulator_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TABLE_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          init_done,
    input  logic [NUM_REQ-1:0]            rq_valid,
    input  logic [NUM_REQ*64-1:0]         rq_addr,
    input  logic [NUM_REQ-1:0]            rq_type,
    input  logic [NUM_REQ*64-1:0]         rq_data,
    output logic [NUM_REQ-1:0]            rq_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [63:0]                   rsp_addr,
    output logic [63:0]                   rsp_data,
    output logic                          mem_req_valid,
    output logic [63:0]                   mem_req_addr,
    output logic                          mem_req_type,
    output logic [31:0]                   mem_req_source_id,
    output logic [63:0]                   mem_req_data,
    input  logic                          mem_req_ready,
    input  logic                          mem_resp_valid,
    input  logic [63:0]                   mem_resp_addr,
    input  logic [63:0]                   mem_resp_data,
    output logic [$clog2(TABLE_DEPTH):0]  inflight_count,
    output logic                          table_full,
    output logic                          err_unmatched
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TABLE_DEPTH);
    localparam int CW = TW + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          rr_last;

    // Outstanding-read table: valid bits are reset, payload is not.
    logic [TABLE_DEPTH-1:0] tbl_valid;
    logic [63:0]            tbl_addr [TABLE_DEPTH];
    logic [IW-1:0]          tbl_src  [TABLE_DEPTH];

    logic [63:0]            req_addr_a [NUM_REQ];
    logic [63:0]            req_data_a [NUM_REQ];
    logic [NUM_REQ-1:0]     addr_hazard;
    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     grant;
    logic                   grant_any;
    logic [IW-1:0]          grant_idx;
    int                     cand;
    logic [TW-1:0]          alloc_idx;
    logic                   resp_hit;
    logic [TW-1:0]          resp_idx;

    // Unpack the flat per-requester buses into indexable arrays.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr_a[i] = rq_addr[i*64 +: 64];
            req_data_a[i] = rq_data[i*64 +: 64];
        end
    end

    // Occupancy from the valid bits; full blocks new reads only.
    always_comb begin
        inflight_count = '0;
        for (int t = 0; t < TABLE_DEPTH; t++)
            inflight_count = inflight_count + CW'(tbl_valid[t]);
    end

    assign table_full = (inflight_count == CW'(TABLE_DEPTH));

    // Same-address hazard against entries valid before this edge, so an entry
    // being freed right now still blocks a new read to its address.
    always_comb begin
        addr_hazard = '0;
        for (int i = 0; i < NUM_REQ; i++)
            for (int t = 0; t < TABLE_DEPTH; t++)
                if (tbl_valid[t] && tbl_addr[t] == req_addr_a[i])
                    addr_hazard[i] = 1'b1;
    end

    // Eligibility per requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            eligible[i] = rq_valid[i] && init_done && !rst && (state_q == IDLE) &&
                          !addr_hazard[i] && (rq_type[i] || !table_full);
    end

    // Round-robin pick starting one past the last granted requester.
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no latch is inferred on the paths that skip an update.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(rr_last) + k) % NUM_REQ;
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = IW'(cand);
            end
        end
        if (grant_any)
            grant[grant_idx] = 1'b1;
    end

    assign rq_ready = grant;

    // Lowest free slot for a read allocation (scan high to low, last hit wins).
    always_comb begin
        alloc_idx = '0;
        for (int t = TABLE_DEPTH - 1; t >= 0; t--)
            if (!tbl_valid[t])
                alloc_idx = TW'(t);
    end

    // Completion lookup; the hazard rule keeps addresses unique in the table.
    always_comb begin
        resp_hit = 1'b0;
        resp_idx = '0;
        for (int t = 0; t < TABLE_DEPTH; t++)
            if (mem_resp_valid && tbl_valid[t] && tbl_addr[t] == mem_resp_addr) begin
                resp_hit = 1'b1;
                resp_idx = TW'(t);
            end
    end

    // Next state: IDLE takes a grant, ISSUE waits for the wrapper handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any)     state_d = ISSUE;
            ISSUE:   if (mem_req_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_req_valid = (state_q == ISSUE);

    // State, request register, table valid bits and response register.
    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            rr_last           <= IW'(NUM_REQ - 1);
            tbl_valid         <= '0;
            mem_req_addr      <= '0;
            mem_req_type      <= 1'b0;
            mem_req_data      <= '0;
            mem_req_source_id <= '0;
            rsp_valid         <= '0;
            rsp_addr          <= '0;
            rsp_data          <= '0;
            err_unmatched     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_any) begin
                rr_last           <= grant_idx;
                mem_req_addr      <= req_addr_a[grant_idx];
                mem_req_type      <= rq_type[grant_idx];
                mem_req_data      <= req_data_a[grant_idx];
                mem_req_source_id <= 32'(grant_idx);
                if (!rq_type[grant_idx])
                    tbl_valid[alloc_idx] <= 1'b1;
            end
            // Free and allocate never target the same slot: the freed slot was
            // valid before the edge, the allocated one was not.
            rsp_valid     <= '0;
            err_unmatched <= mem_resp_valid && !resp_hit;
            if (resp_hit) begin
                tbl_valid[resp_idx]          <= 1'b0;
                rsp_valid[tbl_src[resp_idx]] <= 1'b1;
                rsp_addr                     <= mem_resp_addr;
                rsp_data                     <= mem_resp_data;
            end
        end
    end

    // Table payload written on allocation.
    // NOTE: the payload array is left out of reset on purpose; it is only
    // read when the matching valid bit is set, and the valid bits are reset.
    always_ff @(posedge clk) begin
        if (grant_any && !rq_type[grant_idx]) begin
            tbl_addr[alloc_idx] <= req_addr_a[grant_idx];
            tbl_src[alloc_idx]  <= grant_idx;
        end
    end

endmodule

// File: tb/tb_ramulator_req_arbiter.sv
// Self-checking bench for ramulator_req_arbiter: reset vectors, directed
// multi-cycle scenarios and randomized traffic against a queue-based model.
module tb_ramulator_req_arbiter;

    localparam int N = 4;
    localparam int D = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              init_done;
    logic [N-1:0]      rq_valid;
    logic [N*64-1:0]   rq_addr;
    logic [N-1:0]      rq_type;
    logic [N*64-1:0]   rq_data;
    logic [N-1:0]      rq_ready;
    logic [N-1:0]      rsp_valid;
    logic [63:0]       rsp_addr;
    logic [63:0]       rsp_data;
    logic              mem_req_valid;
    logic [63:0]       mem_req_addr;
    logic              mem_req_type;
    logic [31:0]       mem_req_source_id;
    logic [63:0]       mem_req_data;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [63:0]       mem_resp_addr;
    logic [63:0]       mem_resp_data;
    logic [4:0]        inflight_count;
    logic              table_full;
    logic              err_unmatched;

    ramulator_req_arbiter #(.NUM_REQ(N), .TABLE_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .rq_valid(rq_valid), .rq_addr(rq_addr), .rq_type(rq_type), .rq_data(rq_data),
        .rq_ready(rq_ready), .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_type(mem_req_type),
        .mem_req_source_id(mem_req_source_id), .mem_req_data(mem_req_data),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_addr(mem_resp_addr), .mem_resp_data(mem_resp_data),
        .inflight_count(inflight_count), .table_full(table_full), .err_unmatched(err_unmatched)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [63:0] addr; int src; } ent_t;
    ent_t         m_out[$];   // outstanding reads, order irrelevant
    bit           m_busy;
    int           m_last;
    logic [63:0]  m_addr, m_data, m_rsp_addr, m_rsp_data;
    bit           m_type, m_err;
    int           m_src;
    logic [N-1:0] m_rsp_valid;

    task automatic model_reset();
        m_out.delete();
        m_busy = 0; m_last = N - 1;
        m_addr = 0; m_data = 0; m_type = 0; m_src = 0;
        m_rsp_valid = 0; m_rsp_addr = 0; m_rsp_data = 0; m_err = 0;
    endtask

    function automatic bit m_pending(input logic [63:0] a);
        foreach (m_out[k]) if (m_out[k].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_grant();
        if (rst || !init_done || m_busy) return -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (rq_valid[i] && !m_pending(rq_addr[i*64 +: 64]) && (rq_type[i] || m_out.size() < D))
                return i;
        end
        return -1;
    endfunction

    task automatic model_compare();
        int g;
        g = m_grant();
        check("rq_ready", 64'(rq_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        check("mem_req_valid", 64'(mem_req_valid), 64'(m_busy));
        check("mem_req_addr", mem_req_addr, m_addr);
        check("mem_req_type", 64'(mem_req_type), 64'(m_type));
        check("mem_req_data", mem_req_data, m_data);
        check("mem_req_source_id", 64'(mem_req_source_id), 64'(m_src));
        check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
        check("rsp_addr", rsp_addr, m_rsp_addr);
        check("rsp_data", rsp_data, m_rsp_data);
        check("err_unmatched", 64'(err_unmatched), 64'(m_err));
        check("inflight_count", 64'(inflight_count), 64'(m_out.size()));
        check("table_full", 64'(table_full), 64'(m_out.size() == D));
    endtask

    task automatic model_advance();
        int g, hit;
        if (rst) begin
            model_reset();
            return;
        end
        g = m_grant();
        hit = -1;
        if (mem_resp_valid)
            foreach (m_out[k]) if (m_out[k].addr == mem_resp_addr) hit = k;
        m_rsp_valid = 0;
        m_err = 0;
        if (hit >= 0) begin
            m_rsp_valid = N'(1) << m_out[hit].src;
            m_rsp_addr  = mem_resp_addr;
            m_rsp_data  = mem_resp_data;
            m_out.delete(hit);
        end else if (mem_resp_valid) begin
            m_err = 1;
        end
        if (m_busy && mem_req_ready) m_busy = 0;
        if (g >= 0) begin
            m_busy = 1; m_last = g; m_src = g;
            m_addr = rq_addr[g*64 +: 64];
            m_data = rq_data[g*64 +: 64];
            m_type = rq_type[g];
            if (!rq_type[g]) m_out.push_back('{addr: rq_addr[g*64 +: 64], src: g});
        end
    endtask

    // One clock: compare at the falling edge, advance model at the rising edge.
    task automatic step();
        @(negedge clk);
        model_compare();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        rq_valid = '0; rq_type = '0; rq_addr = '0; rq_data = '0;
        mem_resp_valid = 1'b0; mem_resp_addr = '0; mem_resp_data = '0;
    endtask

    task automatic set_req(input int i, input logic typ, input logic [63:0] a, input logic [63:0] d);
        rq_valid[i] = 1'b1;
        rq_type[i]  = typ;
        rq_addr[i*64 +: 64] = a;
        rq_data[i*64 +: 64] = d;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic         init;
        logic [N-1:0] valid;
        logic [N-1:0] typ;
        logic [N-1:0] exp_ready;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{init: 1'b1, valid: 4'b1111, typ: 4'b0000, exp_ready: 4'b0001};
        vecs[1] = '{init: 1'b1, valid: 4'b1010, typ: 4'b0000, exp_ready: 4'b0010};
        vecs[2] = '{init: 1'b0, valid: 4'b1111, typ: 4'b0000, exp_ready: 4'b0000};
        vecs[3] = '{init: 1'b1, valid: 4'b1000, typ: 4'b1000, exp_ready: 4'b1000};
        vecs[4] = '{init: 1'b1, valid: 4'b0000, typ: 4'b0000, exp_ready: 4'b0000};
        vecs[5] = '{init: 1'b1, valid: 4'b1100, typ: 4'b0100, exp_ready: 4'b0100};

        model_reset();
        init_done = 1'b1;
        mem_req_ready = 1'b1;
        do_reset();

        // Reset state.
        check("reset_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("reset_inflight", 64'(inflight_count), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);

        // First-grant vectors, each from a fresh reset.
        foreach (vecs[v]) begin
            do_reset();
            init_done = vecs[v].init;
            rq_valid  = vecs[v].valid;
            rq_type   = vecs[v].typ;
            for (int i = 0; i < N; i++) rq_addr[i*64 +: 64] = 64'(i) * 64'h40;
            #1;
            check("vec_rq_ready", 64'(rq_ready), 64'(vecs[v].exp_ready));
            step();
        end
        init_done = 1'b1;

        // Continuous reads from all four requesters, each completed while issued.
        do_reset();
        mem_req_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 64'(i) * 64'h40, 64'(i));
        for (int g = 0; g < 12; g++) begin
            mem_resp_valid = 1'b0;
            #1;
            check("rr_ready", 64'(rq_ready), 64'd1 << (g % 4));
            step();
            check("rr_valid", 64'(mem_req_valid), 64'd1);
            check("rr_source", 64'(mem_req_source_id), 64'(g % 4));
            mem_resp_valid = 1'b1;
            mem_resp_addr  = 64'(g % 4) * 64'h40;
            mem_resp_data  = 64'(g);
            step();
        end

        // Single read round trip.
        do_reset();
        set_req(1, 1'b0, 64'h100, 64'h0);
        #1;
        check("rt_ready", 64'(rq_ready), 64'b0010);
        step();
        clear_inputs();
        check("rt_inflight1", 64'(inflight_count), 64'd1);
        step();
        mem_resp_valid = 1'b1; mem_resp_addr = 64'h100; mem_resp_data = 64'h1234;
        step();
        mem_resp_valid = 1'b0;
        check("rt_rsp_valid", 64'(rsp_valid), 64'b0010);
        check("rt_rsp_data", rsp_data, 64'h1234);
        check("rt_inflight0", 64'(inflight_count), 64'd0);
        step();
        check("rt_rsp_clear", 64'(rsp_valid), 64'd0);

        // Unmatched completion.
        do_reset();
        mem_resp_valid = 1'b1; mem_resp_addr = 64'hDEAD0; mem_resp_data = 64'h77;
        step();
        mem_resp_valid = 1'b0;
        check("unm_err", 64'(err_unmatched), 64'd1);
        check("unm_rsp", 64'(rsp_valid), 64'd0);
        step();
        check("unm_err_pulse", 64'(err_unmatched), 64'd0);

        // Same-address hazard held until the completion is consumed.
        do_reset();
        set_req(0, 1'b0, 64'h200, 64'h0);
        step();
        clear_inputs();
        step();
        set_req(3, 1'b0, 64'h200, 64'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("haz_block", 64'(rq_ready), 64'd0);
            step();
        end
        mem_resp_valid = 1'b1; mem_resp_addr = 64'h200; mem_resp_data = 64'h5;
        #1;
        check("haz_free_cycle", 64'(rq_ready), 64'd0);
        step();
        mem_resp_valid = 1'b0;
        #1;
        check("haz_grant", 64'(rq_ready), 64'b1000);
        step();
        clear_inputs();
        check("haz_source", 64'(mem_req_source_id), 64'd3);
        step();

        // Table full: only the write is granted, the read after one completion.
        do_reset();
        for (int k = 0; k < D; k++) begin
            set_req(0, 1'b0, 64'(k) * 64'h40, 64'h0);
            step();
            clear_inputs();
            step();
        end
        check("full_flag", 64'(table_full), 64'd1);
        check("full_count", 64'(inflight_count), 64'd16);
        set_req(0, 1'b0, 64'h1000, 64'h0);
        set_req(2, 1'b1, 64'h2000, 64'hABCD);
        #1;
        check("full_write_only", 64'(rq_ready), 64'b0100);
        step();
        rq_valid[2] = 1'b0;
        step();
        #1;
        check("full_read_blocked", 64'(rq_ready), 64'd0);
        step();
        mem_resp_valid = 1'b1; mem_resp_addr = 64'h0; mem_resp_data = 64'h5;
        #1;
        check("full_still_blocked", 64'(rq_ready), 64'd0);
        step();
        mem_resp_valid = 1'b0;
        #1;
        check("full_read_granted", 64'(rq_ready), 64'b0001);
        step();
        clear_inputs();
        step();

        // Reset with reads outstanding and a request held in ISSUE.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_req(k, 1'b0, 64'h300 + 64'(k) * 64'h40, 64'h0);
            step();
            clear_inputs();
            step();
        end
        mem_req_ready = 1'b0;
        set_req(0, 1'b0, 64'h500, 64'h0);
        step();
        clear_inputs();
        step();
        check("rst_pre_valid", 64'(mem_req_valid), 64'd1);
        check("rst_pre_count", 64'(inflight_count), 64'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_req_ready = 1'b1;
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_mem_req_addr", mem_req_addr, 64'd0);
        check("rst_mem_req_source", 64'(mem_req_source_id), 64'd0);
        check("rst_inflight", 64'(inflight_count), 64'd0);
        check("rst_table_full", 64'(table_full), 64'd0);
        check("rst_rsp_addr", rsp_addr, 64'd0);
        mem_resp_valid = 1'b1; mem_resp_addr = 64'h300; mem_resp_data = 64'h9;
        step();
        mem_resp_valid = 1'b0;
        check("rst_stale_err", 64'(err_unmatched), 64'd1);
        check("rst_stale_rsp", 64'(rsp_valid), 64'd0);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 599) == 0);
            init_done = ($urandom_range(0, 9) != 0);
            mem_req_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < N; i++) begin
                rq_valid[i] = $urandom_range(0, 1);
                rq_type[i]  = ($urandom_range(0, 3) == 0);
                rq_addr[i*64 +: 64] = 64'($urandom_range(0, 31)) * 64'h40;
                rq_data[i*64 +: 64] = {$urandom, $urandom};
            end
            mem_resp_valid = 1'b0;
            mem_resp_data  = {$urandom, $urandom};
            if (m_out.size() > 0 && $urandom_range(0, 3) == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_addr  = m_out[$urandom_range(0, m_out.size() - 1)].addr;
            end else if ($urandom_range(0, 29) == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_addr  = 64'hDEAD0;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ramulator_req_arbiter.md
RAMULATOR_REQ_ARBITER -- requirements
Module: ramulator_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requester ports (2..8).
REQ-002 SHALL have parameter TABLE_DEPTH, default 16, number of outstanding-read tracking entries (power of 2, 2..64).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports:
  clk  in  1  clock, all state on rising edge
  rst  in  1  synchronous active-high reset
  init_done  in  1  memory model ready; no grants while low
  rq_valid  in  NUM_REQ  per-requester request valid
  rq_addr  in  NUM_REQ x 64  per-requester byte address
  rq_type  in  NUM_REQ  0=read, 1=write
  rq_data  in  NUM_REQ x 64  write data
  rq_ready  out  NUM_REQ  one-hot request-accept pulse
  rsp_valid  out  NUM_REQ  one-hot read-response valid
  rsp_addr  out  64  response address (shared)
  rsp_data  out  64  response data (shared)
  mem_req_valid  out  1  request to memory wrapper
  mem_req_addr  out  64  registered address
  mem_req_type  out  1  registered type
  mem_req_source_id  out  32  granted requester index, zero-extended
  mem_req_data  out  64  registered write data
  mem_req_ready  in  1  wrapper accepts this cycle
  mem_resp_valid  in  1  wrapper read completion
  mem_resp_addr  in  64  completion address
  mem_resp_data  in  64  completion data
  inflight_count  out  $clog2(TABLE_DEPTH)+1  valid table entries
  table_full  out  1  inflight_count == TABLE_DEPTH
  err_unmatched  out  1  one-cycle pulse: completion with no matching entry

Function
REQ-005 SHALL implement FSM {IDLE, ISSUE}; IDLE: output register empty, mem_req_valid=0; ISSUE: mem_req_valid=1, register held stable.
REQ-006 Requester i SHALL be eligible iff rq_valid[i], init_done=1, state=IDLE, rq_addr[i] matches no valid table entry, and (rq_type[i]=1 or table not full).
REQ-007 SHALL grant among eligible requesters round-robin, starting search at (last granted index + 1) mod NUM_REQ; last-granted pointer resets to NUM_REQ-1 (requester 0 first).
REQ-008 On grant, rq_ready[i] SHALL be 1 combinationally that cycle; on that edge addr/type/data/source_id latch into mem_req_* and state -> ISSUE.
REQ-009 On grant of a read, SHALL allocate the lowest-index free entry on the same edge, storing address and source index.
REQ-010 In ISSUE, when mem_req_ready=1, state SHALL -> IDLE; no grant possible in ISSUE (minimum 2 cycles per request).
REQ-011 Writes SHALL allocate no entry and produce no rsp_valid.
REQ-012 On mem_resp_valid, SHALL compare mem_resp_addr against all valid entries (at most one matches due to REQ-006); on match, next cycle rsp_valid[src]=1 with rsp_addr/rsp_data registered, and entry freed on that edge.
REQ-013 Unmatched completion SHALL be dropped, err_unmatched=1 the following cycle, no rsp_valid.
REQ-014 Allocate and free in same cycle SHALL both take effect; inflight_count unchanged.
REQ-015 Hazard check of REQ-006 SHALL use pre-edge valid bits: a read to an address being freed this cycle is not eligible until next cycle.
REQ-016 init_done falling SHALL stop new grants only; a request in ISSUE completes; table keeps tracking completions.
REQ-017 rsp_valid SHALL be at most one-hot; rq_ready SHALL be at most one-hot.

Reset
REQ-018 On rst=1 SHALL: state=IDLE, all table entries invalid, rq_ready=0, rsp_valid=0, mem_req_valid=0, mem_req_addr/type/data/source_id=0, rsp_addr/rsp_data=0, inflight_count=0, table_full=0, err_unmatched=0, RR pointer=NUM_REQ-1.
REQ-019 Reset mid-operation SHALL abandon any ISSUE request and all outstanding reads; completions arriving afterwards are treated per REQ-013.

Verification
REQ-020 All 4 requesters issue reads continuously to distinct addresses 0x0,0x40,0x80,0xC0, mem_req_ready=1 -> mem_req_source_id sequence 0,1,2,3,0..., one grant every 2 cycles.
REQ-021 Requester 1 read 0x100 accepted, completion addr=0x100 data=0x1234 -> exactly rsp_valid[1]=1 one cycle later, rsp_data=0x1234, inflight_count 1->0.
REQ-022 16 reads outstanding (table_full=1), requester 0 read and requester 2 write pending -> only write granted; after one completion read granted.
REQ-023 Read 0x200 outstanding, requester 3 read 0x200 -> rq_ready[3] held 0 until completion for 0x200 is consumed, then granted.
REQ-024 mem_resp_valid with addr 0xDEAD0 not in table -> err_unmatched one-cycle pulse, rsp_valid stays 0.
REQ-025 rst asserted with 5 reads outstanding and mem_req_valid=1 -> next cycle all outputs at REQ-018 values; later completion for an old address -> err_unmatched pulse.
